serializer_stream: RTL and testbench
====================================

Name: serializer_stream

Overview:
- Parametrised successor to the single-word serializer.
- Accepts parallel words over a valid/ready handshake and emits them as a 1-bit stream with a per-word length and a per-word bit order.
- A one-entry holding register allows gapless back-to-back words.
- Sits between packet/CRC logic and pin-level line drivers.

Parameters:
- DATA_W, 16: parallel word width, >= 4.
- MOD_W, $clog2(DATA_W): width of the length field.
- MOD_IGNORE_LO, 1: lowest length value that is dropped.
- MOD_IGNORE_HI, 2: highest length value that is dropped. Setting LO > HI disables dropping.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- arst_i  in  1  reset, asynchronous, active-high.
- data_i  in  DATA_W  parallel word.
- data_mod_i  in  MOD_W  bit count; 0 means DATA_W bits.
- data_lsb_first_i  in  1  0 = MSB-first from bit DATA_W-1; 1 = LSB-first from bit 0.
- data_val_i  in  1  word valid.
- data_rdy_o  out  1  block can accept a word.
- ser_data_o  out  1  serial bit; 0 when ser_data_val_o = 0.
- ser_data_val_o  out  1  serial bit valid.
- ser_last_o  out  1  high with the final bit of a word.
- busy_o  out  1  shifting, or holding register occupied.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-word):
  - All state is cleared and the holding register is emptied.
  - Outputs: ser_data_o = 0, ser_data_val_o = 0, ser_last_o = 0, busy_o = 0, data_rdy_o = 1.
  - A word in flight is lost, with no partial last.
- Handshake:
  - A transfer occurs when data_val_i && data_rdy_o at a rising edge.
  - data_rdy_o = !hold_full. It is registered and has no combinational path from data_val_i.
- Length: eff_len = (data_mod_i == 0) ? DATA_W : data_mod_i. The counter is MOD_W+1 bits so DATA_W is representable.
- Drop rule:
  - A word with MOD_IGNORE_LO <= data_mod_i <= MOD_IGNORE_HI is accepted (the handshake completes) and then discarded.
  - It produces no serial output and never occupies the shifter.
- FSM states:
  - IDLE: shifter empty. On an accepted non-dropped word go to SHIFT. The first bit appears on the cycle after acceptance (latency 1).
  - SHIFT: one bit per cycle with ser_data_val_o = 1. The counter counts from 1 to eff_len; ser_last_o = 1 when counter == eff_len.
    - On the last bit, if the holding register is full, load it into the shifter. Its first bit appears the next cycle (no gap) and the state stays SHIFT.
    - On the last bit, if an accepted non-dropped word arrives in that same cycle, load it directly. The next cycle carries its first bit and the holding register stays empty.
    - Otherwise go to IDLE.
  - A word accepted while in SHIFT (not on the last bit) goes to the holding register.
- Bit order and length:
  - Bit order is latched per word.
  - MSB-first emits data[DATA_W-1] down to data[DATA_W-eff_len].
  - LSB-first emits data[0] up to data[eff_len-1].
- Simultaneous events:
  - Acceptance and holding-register drain in the same cycle are legal.
  - data_rdy_o deasserts only when the holding register is full and the shifter is not on its last bit.
- busy_o = (state == SHIFT) || hold_full.

Optional Feature:
- Macro: SERIALIZER_STREAM_PARITY_EN.
- When defined:
  - After the last data bit, one extra cycle emits the even parity (XOR) of the eff_len transmitted bits.
  - ser_data_val_o = 1 and ser_last_o = 1 on the parity cycle; ser_last_o is not asserted on the last data bit.
  - Back-to-back loading happens on the parity cycle.
  - FSM gains state PARITY.
- When undefined: no PARITY state and no parity logic; behaviour is exactly as described above.

Decomposition:
- Package serializer_stream_pkg:
  - state enum (IDLE, SHIFT, PARITY).
  - word record typedef {data, len, lsb_first}.
  - function eff_len_f(mod).
  - function is_dropped_f(mod).
- Sub-module serializer_stream_hold: one-entry holding register with full flag and load/drain strobes.

Test Plan:
- Reset, then word 16'hA5C3, mod 0, MSB-first -> 16 valid bits 1010_0101_1100_0011; ser_last_o on bit 16; first bit one cycle after acceptance.
- Word 16'h000B, mod 4, LSB-first -> bits 1,1,0,1; last on the 4th bit; busy_o falls the cycle after.
- Words with mod 1 and mod 2 -> data_rdy_o stays 1; zero serial valid cycles; busy_o stays 0.
- Three words (mod 3, 0, 5) presented back-to-back with data_val_i held high -> 3+16+5 contiguous valid cycles with no gaps; data_rdy_o low while the holding register is full.
- Assert arst_i asynchronously at bit 7 of a 16-bit word -> outputs clear before the next edge; after release, data_rdy_o = 1 and a new word serialises correctly.
- With SERIALIZER_STREAM_PARITY_EN: word 8'b...0111 (mod 3, LSB-first) -> bits 1,1,1 then parity bit 1 with last; 4 valid cycles.

Source files
------------

// File: rtl/serializer_stream_pkg.sv
// Shared types and helpers for serializer_stream.
//   state_e      : serializer FSM states (PARITY is only reachable when
//                  SERIALIZER_STREAM_PARITY_EN is defined)
//   eff_len_f    : length field -> number of bits to emit (0 means full width)
//   is_dropped_f : true when a length falls inside the discard window
package serializer_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // A zero length field encodes a full-width word.
    function automatic int unsigned eff_len_f(input int unsigned mod, input int unsigned data_w);
        return (mod == 0) ? data_w : mod;
    endfunction

    // An empty window (lo > hi) never matches.
    function automatic logic is_dropped_f(input int unsigned mod, input int unsigned lo,
                                          input int unsigned hi);
        return (mod >= lo) && (mod <= hi);
    endfunction

endpackage

// File: rtl/serializer_stream_hold.sv
// One-entry holding register for serializer_stream.
// Ports:
//   clk_i, arst_i : clock, asynchronous active-high reset
//   load_i        : capture word_i (wins over drain_i in the same cycle)
//   drain_i       : entry consumed by the shifter this cycle
//   word_i        : word to capture
//   full_o        : entry occupied (registered)
//   word_o        : stored word (registered)
module serializer_stream_hold #(
    parameter type word_t = logic
) (
    input  logic  clk_i,
    input  logic  arst_i,
    input  logic  load_i,
    input  logic  drain_i,
    input  word_t word_i,
    output logic  full_o,
    output word_t word_o
);

    logic  full_q, full_d;
    word_t word_q, word_d;

    // Drain then load, so a simultaneous drain+load keeps the entry full.
    always_comb begin
        full_d = full_q;
        word_d = word_q;
        if (drain_i) begin
            full_d = 1'b0;
        end
        if (load_i) begin
            full_d = 1'b1;
            word_d = word_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            full_q <= 1'b0;
            word_q <= '0;
        end else begin
            full_q <= full_d;
            word_q <= word_d;
        end
    end

    assign full_o = full_q;
    assign word_o = word_q;

endmodule

// File: rtl/serializer_stream.sv
// Parallel-to-serial stream converter with per-word length and bit order.
// A one-entry holding register lets words follow each other without gaps.
// Optional macro SERIALIZER_STREAM_PARITY_EN appends an even-parity bit
// (carrying ser_last_o) after the data bits of every word.
// Ports:
//   clk_i, arst_i    : clock, asynchronous active-high reset
//   data_i           : parallel word
//   data_mod_i       : bit count, 0 = DATA_W
//   data_lsb_first_i : 1 = emit from bit 0 upwards, 0 = from bit DATA_W-1 down
//   data_val_i       : word valid
//   data_rdy_o       : word can be accepted (registered)
//   ser_data_o       : serial bit, 0 when not valid
//   ser_data_val_o   : serial bit valid
//   ser_last_o       : final bit of a word
//   busy_o           : shifting or holding register occupied
module serializer_stream
    import serializer_stream_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned MOD_W         = $clog2(DATA_W),
    parameter int unsigned MOD_IGNORE_LO = 1,
    parameter int unsigned MOD_IGNORE_HI = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_lsb_first_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_last_o,
    output logic              busy_o
);

    // Counter is one bit wider than the length field so DATA_W fits.
    localparam int unsigned CNT_W = MOD_W + 1;

    // Word record as stored in the holding register, length already resolved.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  len;
        logic              lsb_first;
    } word_t;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              lsb_q, lsb_d;
`ifdef SERIALIZER_STREAM_PARITY_EN
    logic              par_q, par_d;
`endif

    logic ser_data_q, ser_data_d;
    logic ser_val_q,  ser_val_d;
    logic ser_last_q, ser_last_d;
    logic busy_q,     busy_d;
    logic rdy_q,      rdy_d;

    logic  accept, keep, load_pt;
    logic  hold_load, hold_drain, hold_full, hold_full_d;
    word_t in_word, hold_word, ld_word;

    assign in_word.data      = data_i;
    assign in_word.len       = CNT_W'(eff_len_f(32'(data_mod_i), DATA_W));
    assign in_word.lsb_first = data_lsb_first_i;

    serializer_stream_hold #(
        .word_t (word_t)
    ) u_hold (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .load_i  (hold_load),
        .drain_i (hold_drain),
        .word_i  (in_word),
        .full_o  (hold_full),
        .word_o  (hold_word)
    );

    // Next state, shifter update and next registered outputs.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        lsb_d       = lsb_q;
`ifdef SERIALIZER_STREAM_PARITY_EN
        par_d       = par_q;
`endif
        hold_load   = 1'b0;
        hold_drain  = 1'b0;
        ser_data_d  = 1'b0;
        ser_val_d   = 1'b0;
        ser_last_d  = 1'b0;
        busy_d      = 1'b0;
        rdy_d       = 1'b1;
        hold_full_d = 1'b0;

        accept  = data_val_i && rdy_q;
        keep    = accept && !is_dropped_f(32'(data_mod_i), MOD_IGNORE_LO, MOD_IGNORE_HI);
        // Holding register has priority: it was accepted first.
        ld_word = hold_full ? hold_word : in_word;

        // Load point: the shifter may take a new word at this edge.
`ifdef SERIALIZER_STREAM_PARITY_EN
        load_pt = (state_q == IDLE) || (state_q == PARITY);
`else
        load_pt = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == len_q));
`endif

        if (load_pt) begin
            if (hold_full || keep) begin
                state_d    = SHIFT;
                sh_d       = ld_word.data;
                cnt_d      = CNT_W'(1);
                len_d      = ld_word.len;
                lsb_d      = ld_word.lsb_first;
`ifdef SERIALIZER_STREAM_PARITY_EN
                par_d      = ld_word.lsb_first ? ld_word.data[0] : ld_word.data[DATA_W-1];
`endif
                hold_drain = hold_full;
                // A new word arriving while the holding register drains refills it.
                hold_load  = hold_full && keep;
            end else begin
                state_d = IDLE;
            end
        end else begin
            hold_load = keep;
            if (cnt_q != len_q) begin
                sh_d  = lsb_q ? (sh_q >> 1) : (sh_q << 1);
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIALIZER_STREAM_PARITY_EN
                par_d = par_q ^ (lsb_q ? sh_q[1] : sh_q[DATA_W-2]);
`endif
            end
`ifdef SERIALIZER_STREAM_PARITY_EN
            else begin
                state_d = PARITY;
            end
`endif
        end

        ser_val_d = (state_d != IDLE);
        if (state_d == SHIFT) begin
            ser_data_d = lsb_d ? sh_d[0] : sh_d[DATA_W-1];
        end
`ifdef SERIALIZER_STREAM_PARITY_EN
        if (state_d == PARITY) begin
            ser_data_d = par_d;
        end
        ser_last_d = (state_d == PARITY);
`else
        ser_last_d = (state_d == SHIFT) && (cnt_d == len_d);
`endif

        hold_full_d = hold_load || (hold_full && !hold_drain);
        busy_d      = (state_d != IDLE) || hold_full_d;
        // On the last cycle of a word the holding register drains, so a word can be taken.
        rdy_d       = !hold_full_d || ser_last_d;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            lsb_q      <= 1'b0;
`ifdef SERIALIZER_STREAM_PARITY_EN
            par_q      <= 1'b0;
`endif
            ser_data_q <= 1'b0;
            ser_val_q  <= 1'b0;
            ser_last_q <= 1'b0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            lsb_q      <= lsb_d;
`ifdef SERIALIZER_STREAM_PARITY_EN
            par_q      <= par_d;
`endif
            ser_data_q <= ser_data_d;
            ser_val_q  <= ser_val_d;
            ser_last_q <= ser_last_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
        end
    end

    assign data_rdy_o     = rdy_q;
    assign ser_data_o     = ser_data_q;
    assign ser_data_val_o = ser_val_q;
    assign ser_last_o     = ser_last_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer_stream.sv
// Testbench for serializer_stream (DATA_W = 16, drop window 1..2).
// Stimulus pushes expected serial bits into a queue; a monitor pops and
// compares on every valid serial cycle. Honours SERIALIZER_STREAM_PARITY_EN.
module tb_serializer_stream;

    logic        clk = 1'b0;
    logic        arst_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  data_mod_i = '0;
    logic        data_lsb_first_i = 1'b0;
    logic        data_val_i = 1'b0;
    logic        data_rdy_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        ser_last_o;
    logic        busy_o;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   run     = 0;
    int   last_run = 0;

    always #5 clk = ~clk;

    serializer_stream #(
        .DATA_W(16)
    ) dut (
        .clk_i            (clk),
        .arst_i           (arst_i),
        .data_i           (data_i),
        .data_mod_i       (data_mod_i),
        .data_lsb_first_i (data_lsb_first_i),
        .data_val_i       (data_val_i),
        .data_rdy_o       (data_rdy_o),
        .ser_data_o       (ser_data_o),
        .ser_data_val_o   (ser_data_val_o),
        .ser_last_o       (ser_last_o),
        .busy_o           (busy_o)
    );

    task automatic check(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Expected serial bits for one word: length, order, drop window, optional parity.
    function automatic void push_exp(input logic [15:0] d, input int m, input logic lsb);
        int   len;
        logic par;
        exp_t e;
        if (m >= 1 && m <= 2) return;
        len = (m == 0) ? 16 : m;
        par = 1'b0;
        for (int i = 0; i < len; i++) begin
            e.b    = lsb ? d[i] : d[15-i];
            par    = par ^ e.b;
`ifdef SERIALIZER_STREAM_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == len - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef SERIALIZER_STREAM_PARITY_EN
        e.b    = par;
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] d, input int m, input logic lsb, output int waits);
        data_i           = d;
        data_mod_i       = 4'(m);
        data_lsb_first_i = lsb;
        data_val_i       = 1'b1;
        waits            = 0;
        while (!data_rdy_o && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!data_rdy_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: data_rdy_o stuck at %b, expected 1", data_rdy_o);
            data_val_i = 1'b0;
            return;
        end
        push_exp(d, m, lsb);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy_o || exp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy_o || exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy_o=%b pending=%0d, expected idle", busy_o, exp_q.size());
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ser_data_val_o) begin
                run++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_bit: got data=%b last=%b, expected no valid", ser_data_o, ser_last_o);
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (ser_data_o !== e.b || ser_last_o !== e.last) begin
                        n_fail++;
                        $display("FAIL serial_bit: got data=%b last=%b, expected data=%b last=%b at %0t",
                                 ser_data_o, ser_last_o, e.b, e.last, $time);
                    end
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                check("idle_data_zero", ser_data_o | ser_last_o, 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset state
        #1 arst_i = 1'b1;
        #2;
        check("rst_rdy",  data_rdy_o, 1'b1);
        check("rst_val",  ser_data_val_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_last", ser_last_o, 1'b0);
        @(negedge clk);
        arst_i = 1'b0;
        @(negedge clk);

        // Full-width MSB-first word, first bit one cycle after acceptance
        send(16'hA5C3, 0, 1'b0, w);
        data_val_i = 1'b0;
        check("lat1_val",  ser_data_val_o, 1'b1);
        check("lat1_data", ser_data_o, 1'b1);
        wait_idle();

        // 4-bit LSB-first word: 1,1,0,1; busy falls the cycle after the last cycle
        send(16'h000B, 4, 1'b1, w);
        data_val_i = 1'b0;
        w = 0;
        while (!ser_last_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("lsb4_last_seen", ser_last_o, 1'b1);
        check("lsb4_busy_on_last", busy_o, 1'b1);
        @(negedge clk);
        check("lsb4_busy_after", busy_o, 1'b0);
        check("lsb4_val_after", ser_data_val_o, 1'b0);
        wait_idle();

        // Dropped lengths 1 and 2
        send(16'hFFFF, 1, 1'b0, w);
        check("drop1_rdy",  data_rdy_o, 1'b1);
        check("drop1_busy", busy_o, 1'b0);
        check("drop1_val",  ser_data_val_o, 1'b0);
        send(16'hFFFF, 2, 1'b1, w);
        data_val_i = 1'b0;
        check("drop2_rdy",  data_rdy_o, 1'b1);
        check("drop2_busy", busy_o, 1'b0);
        check("drop2_val",  ser_data_val_o, 1'b0);
        @(negedge clk);
        check("drop_quiet_busy", busy_o, 1'b0);
        check("drop_quiet_val",  ser_data_val_o, 1'b0);

        // Back-to-back lengths 3, 16, 5 with valid held high
        send(16'hA000, 3, 1'b0, w);
        send(16'h1234, 0, 1'b0, w);
        send(16'h0015, 5, 1'b1, w);
`ifdef SERIALIZER_STREAM_PARITY_EN
        check_int("b2b_w3_wait", w, 2);
`else
        check_int("b2b_w3_wait", w, 1);
`endif
        data_val_i = 1'b0;
        check("b2b_rdy_hold_full", data_rdy_o, 1'b0);
        check("b2b_busy", busy_o, 1'b1);
        wait_idle();
        @(negedge clk);
`ifdef SERIALIZER_STREAM_PARITY_EN
        check_int("b2b_run_len", last_run, 27);
`else
        check_int("b2b_run_len", last_run, 24);
`endif

        // Asynchronous reset at bit 7 of a 16-bit word
        send(16'hFFFF, 0, 1'b0, w);
        data_val_i = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_val", ser_data_val_o, 1'b1);
        #2 arst_i = 1'b1;
        #1;
        check("arst_val",  ser_data_val_o, 1'b0);
        check("arst_data", ser_data_o, 1'b0);
        check("arst_last", ser_last_o, 1'b0);
        check("arst_busy", busy_o, 1'b0);
        check("arst_rdy",  data_rdy_o, 1'b1);
        exp_q.delete();
        @(negedge clk);
        #2 arst_i = 1'b0;
        @(negedge clk);
        check("post_rst_rdy",  data_rdy_o, 1'b1);
        check("post_rst_busy", busy_o, 1'b0);
        send(16'h5A3C, 0, 1'b1, w);
        data_val_i = 1'b0;
        wait_idle();

`ifdef SERIALIZER_STREAM_PARITY_EN
        // 3 LSB-first ones then parity bit 1 carrying last
        send(16'h0007, 3, 1'b1, w);
        data_val_i = 1'b0;
        wait_idle();
        @(negedge clk);
        check_int("par_run_len", last_run, 4);
`endif

        check_int("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
